buffer_link_arbiter: RTL and testbench

Round-robin arbiter that shares the single downstream buffer write port among four link requesters. Each link requests a single-beat or multi-width (two-beat) transfer. The arbiter selects a winner and drives the buffer mux select (`link_num`) and the write strobe. It also returns per-link ack and full back-pressure. It sits between the link-side buffers and the buffer mux controller.

---
 rtl/buffer_link_arbiter.sv | 121 ++++++++++++
 tb/tb_buffer_link_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_link_arbiter.sv
// rtl/buffer_link_arbiter.sv - round-robin arbiter sharing one buffer write port among four links
module buffer_link_arbiter #(
  parameter int DATA_WIDTH = 40,
  parameter int NUM_LINKS  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_LINKS-1:0]            i_req,
  input  logic [NUM_LINKS-1:0]            i_multi_width,
  input  logic [NUM_LINKS*DATA_WIDTH-1:0] i_link_data,
  input  logic                            i_buf_full,
  output logic [NUM_LINKS-1:0]            o_grant,
  output logic [1:0]                      o_link_num,
  output logic [NUM_LINKS-1:0]            o_ack,
  output logic [NUM_LINKS-1:0]            o_out_full,
  output logic                            o_buf_wr,
  output logic [DATA_WIDTH-1:0]           o_buf_data,
  output logic                            o_abort
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]           r_state;
  logic [1:0]           r_rr_ptr;
  logic [1:0]           r_winner;
  logic                 r_multi;
  logic                 r_beat;
  logic                 r_abort;

  logic [NUM_LINKS-1:0] w_onehot;
  logic [NUM_LINKS-1:0] w_arb_req;
  logic [1:0]           w_cand;
  logic [1:0]           w_arb_idx;
  logic                 w_arb_any;
  logic                 w_xfer;
  logic                 w_final;
  logic                 w_buf_wr;

  assign w_xfer   = (r_state == XFER);
  assign w_onehot = 4'b0001 << r_winner;
  assign w_final  = !r_multi || r_beat;
  // Reset wins over an in-flight beat, so the strobe is masked in the reset cycle.
  assign w_buf_wr = w_xfer && !i_buf_full && i_req[r_winner] && !i_rst;

  // The finishing link's req is still up for its last beat; it must not re-win here.
  assign w_arb_req = w_xfer ? (i_req & ~w_onehot) : i_req;

  always_comb begin
    w_arb_any = 1'b0;
    w_arb_idx = r_rr_ptr;
    w_cand    = r_rr_ptr;
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      w_cand = r_rr_ptr + 2'(k);
      if (w_arb_req[w_cand]) begin
        w_arb_any = 1'b1;
        w_arb_idx = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= 2'd0;
      r_winner <= 2'd0;
      r_multi  <= 1'b0;
      r_beat   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_winner <= w_arb_idx;
            r_multi  <= i_multi_width[w_arb_idx];
            r_beat   <= 1'b0;
            r_rr_ptr <= w_arb_idx + 2'd1;
            r_state  <= XFER;
          end
        end
        default: begin
          if (!i_req[r_winner]) begin
            r_abort <= 1'b1;
            r_beat  <= 1'b0;
            r_state <= IDLE;
          end else if (w_buf_wr) begin
            if (!w_final) begin
              r_beat <= 1'b1;
            end else if (w_arb_any) begin
              r_winner <= w_arb_idx;
              r_multi  <= i_multi_width[w_arb_idx];
              r_beat   <= 1'b0;
              r_rr_ptr <= w_arb_idx + 2'd1;
            end else begin
              r_beat  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    case (r_winner)
      2'd1:    o_buf_data = i_link_data[1*DATA_WIDTH +: DATA_WIDTH];
      2'd2:    o_buf_data = i_link_data[2*DATA_WIDTH +: DATA_WIDTH];
      2'd3:    o_buf_data = i_link_data[3*DATA_WIDTH +: DATA_WIDTH];
      default: o_buf_data = i_link_data[0 +: DATA_WIDTH];
    endcase
  end

  assign o_grant    = w_xfer ? w_onehot : '0;
  assign o_link_num = r_winner;
  assign o_buf_wr   = w_buf_wr;
  assign o_ack      = w_buf_wr ? o_grant : '0;
  assign o_out_full = ~(o_grant & {NUM_LINKS{!i_buf_full}});
  assign o_abort    = r_abort;

endmodule

// File: tb/tb_buffer_link_arbiter.sv
// tb/tb_buffer_link_arbiter.sv - directed self-checking bench for buffer_link_arbiter
module tb_buffer_link_arbiter;

  localparam int DW = 40;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    multi_width;
  logic [4*DW-1:0] link_data;
  logic          buf_full;
  logic [3:0]    grant;
  logic [1:0]    link_num;
  logic [3:0]    ack;
  logic [3:0]    out_full;
  logic          buf_wr;
  logic [DW-1:0] buf_data;
  logic          abort;

  int n_pass;
  int n_total;
  logic [DW-1:0] d [4];

  buffer_link_arbiter #(.DATA_WIDTH(DW), .NUM_LINKS(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_multi_width (multi_width),
    .i_link_data   (link_data),
    .i_buf_full    (buf_full),
    .o_grant       (grant),
    .o_link_num    (link_num),
    .o_ack         (ack),
    .o_out_full    (out_full),
    .o_buf_wr      (buf_wr),
    .o_buf_data    (buf_data),
    .o_abort       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; multi_width = 4'b0; buf_full = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = {8'(8'h11 * (i + 1)), 32'hDEADBEEF ^ 32'(i * 32'h01010101)};
      link_data[i*DW +: DW] = d[i];
    end

    // reset state
    rst = 1'b1; req = 4'b0; multi_width = 4'b0; buf_full = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_link_num", 64'(link_num), 64'h0);
    chk("rst_buf_wr", 64'(buf_wr), 64'h0);
    chk("rst_abort", 64'(abort), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_out_full", 64'(out_full), 64'hF);
    rst = 1'b0;

    // single beat on link 2
    req = 4'b0100;
    #1;
    chk("t1_idle_wr", 64'(buf_wr), 64'h0);
    next_cycle();
    #1;
    chk("t1_grant", 64'(grant), 64'h4);
    chk("t1_link_num", 64'(link_num), 64'h2);
    chk("t1_buf_wr", 64'(buf_wr), 64'h1);
    chk("t1_buf_data", 64'(buf_data), 64'(d[2]));
    chk("t1_ack", 64'(ack), 64'h4);
    chk("t1_out_full", 64'(out_full), 64'hB);
    next_cycle();
    req = 4'b0;
    #1;
    chk("t1_idle_grant", 64'(grant), 64'h0);
    chk("t1_idle_wr2", 64'(buf_wr), 64'h0);

    // all four held from reset: 0,1,2,3,0 with no bubble
    rst = 1'b1; req = 4'b1111; multi_width = 4'b0; buf_full = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("t2_idle_grant", 64'(grant), 64'h0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      chk($sformatf("t2_grant%0d", k), 64'(grant), 64'(4'b0001 << (k % 4)));
      chk($sformatf("t2_wr%0d", k), 64'(buf_wr), 64'h1);
      chk($sformatf("t2_data%0d", k), 64'(buf_data), 64'(d[k % 4]));
    end

    // two-beat transfer on link 1; mid-transfer multi_width change ignored
    do_reset();
    req = 4'b0010; multi_width = 4'b0010;
    next_cycle();
    #1;
    chk("t3_grant_b0", 64'(grant), 64'h2);
    chk("t3_link_b0", 64'(link_num), 64'h1);
    chk("t3_ack_b0", 64'(ack), 64'h2);
    multi_width = 4'b0;
    next_cycle();
    #1;
    chk("t3_grant_b1", 64'(grant), 64'h2);
    chk("t3_wr_b1", 64'(buf_wr), 64'h1);
    chk("t3_ack_b1", 64'(ack), 64'h2);
    next_cycle();
    req = 4'b0;
    #1;
    chk("t3_idle_grant", 64'(grant), 64'h0);
    chk("t3_idle_wr", 64'(buf_wr), 64'h0);

    // link 3 stalled by buf_full for 3 cycles
    do_reset();
    req = 4'b1000;
    next_cycle();
    buf_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      #1;
      chk($sformatf("t4_grant%0d", k), 64'(grant), 64'h8);
      chk($sformatf("t4_wr%0d", k), 64'(buf_wr), 64'h0);
      chk($sformatf("t4_full%0d", k), 64'(out_full), 64'hF);
    end
    next_cycle();
    buf_full = 1'b0;
    #1;
    chk("t4_release_wr", 64'(buf_wr), 64'h1);
    chk("t4_release_ack", 64'(ack), 64'h8);
    chk("t4_release_full", 64'(out_full), 64'h7);
    next_cycle();
    req = 4'b0;
    #1;
    chk("t4_idle_grant", 64'(grant), 64'h0);

    // link 0 drops req after its first beat; link 1 follows
    do_reset();
    req = 4'b0001; multi_width = 4'b0001;
    next_cycle();
    #1;
    chk("t5_b0_wr", 64'(buf_wr), 64'h1);
    next_cycle();
    req = 4'b0010;
    #1;
    chk("t5_drop_wr", 64'(buf_wr), 64'h0);
    chk("t5_drop_ack", 64'(ack), 64'h0);
    chk("t5_drop_abort", 64'(abort), 64'h0);
    next_cycle();
    #1;
    chk("t5_abort", 64'(abort), 64'h1);
    chk("t5_abort_grant", 64'(grant), 64'h0);
    next_cycle();
    #1;
    chk("t5_abort_clear", 64'(abort), 64'h0);
    chk("t5_next_grant", 64'(grant), 64'h2);
    chk("t5_next_link", 64'(link_num), 64'h1);
    chk("t5_next_wr", 64'(buf_wr), 64'h1);
    next_cycle();
    req = 4'b0;

    // reset during second beat, then 2 and 0 together -> 0 first
    do_reset();
    req = 4'b0010; multi_width = 4'b0010;
    next_cycle();
    #1;
    chk("t6_b0_wr", 64'(buf_wr), 64'h1);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("t6_rst_cycle_wr", 64'(buf_wr), 64'h0);
    next_cycle();
    rst = 1'b0; req = 4'b0101; multi_width = 4'b0;
    #1;
    chk("t6_post_grant", 64'(grant), 64'h0);
    chk("t6_post_link", 64'(link_num), 64'h0);
    chk("t6_post_wr", 64'(buf_wr), 64'h0);
    next_cycle();
    #1;
    chk("t6_first", 64'(grant), 64'h1);
    next_cycle();
    #1;
    chk("t6_second", 64'(grant), 64'h4);
    chk("t6_second_data", 64'(buf_data), 64'(d[2]));
    req = 4'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
